// File: rtl/score_pkg.sv
// Shared types and constants for the score tracker.
//   bcd_digit_t / bcd_score_t : one BCD digit / four-digit BCD score
//   state_t                   : tracker FSM state (RUN, HOLD, OVER)
//   SCORE_MAX, BCD_DIGIT_MAX  : saturation value and per-digit limit
//   bcd_gt()                  : digit-wise greater-than, MSD first
package score_pkg;

  typedef logic [3:0]       bcd_digit_t;
  typedef bcd_digit_t [3:0] bcd_score_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam bcd_score_t SCORE_MAX     = 16'h9999;
  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;

  // First differing digit from the MSD decides the comparison.
  function automatic logic bcd_gt(input bcd_score_t a, input bcd_score_t b);
    logic gt, decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        gt      = (a[i] > b[i]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/score_tracker_if.sv
// Signal bundle for score_tracker.
//   inputs : i_v_sync (async frame strobe), i_scored, i_is_finished,
//            i_is_dead (async levels), i_restart (sync one-cycle pulse)
//   outputs: o_score_bcd, o_best_bcd, o_score_event, o_state
// master = stimulus side, slave = tracker side.
interface score_tracker_if;
  logic        i_v_sync;
  logic        i_scored;
  logic        i_is_finished;
  logic        i_is_dead;
  logic        i_restart;
  logic [15:0] o_score_bcd;
  logic [15:0] o_best_bcd;
  logic        o_score_event;
  logic [1:0]  o_state;

  modport master (
    output i_v_sync, i_scored, i_is_finished, i_is_dead, i_restart,
    input  o_score_bcd, o_best_bcd, o_score_event, o_state
  );

  modport slave (
    input  i_v_sync, i_scored, i_is_finished, i_is_dead, i_restart,
    output o_score_bcd, o_best_bcd, o_score_event, o_state
  );
endinterface

// File: rtl/bcd_digit_add.sv
// One BCD digit adder: sum = a + b + cin, wrapped into 0..9 with cout.
//   a, b : input BCD digits; cin : carry in
//   sum  : result digit;     cout: carry out to the next digit
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [4:0] raw;
  logic [4:0] adj;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    adj  = raw - 5'd10;
    cout = (raw > {1'b0, BCD_DIGIT_MAX});
    sum  = cout ? adj[3:0] : raw[3:0];
  end
endmodule

// File: rtl/score_tracker.sv
// Coin score tracker: credits at most one coin per video frame, BCD score
// with saturation at 9999, game-over freeze and restart.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : score_tracker_if.slave (inputs/outputs listed there)
// Optional feature: define SCORE_TRACKER_BEST_EN to build the best-score
// register; otherwise o_best_bcd is tied to 0000.
module score_tracker
  import score_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int POINTS_PER_COIN = 1
) (
  input logic           i_clk,
  input logic           i_rst,
  score_tracker_if.slave bus
);
  localparam bcd_digit_t ADDEND0 = bcd_digit_t'(POINTS_PER_COIN);

  // Synchronisers and edge history
  logic [SYNC_STAGES-1:0] vs_sync, sc_sync, fin_sync, dead_sync;
  logic vs_d, sc_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_sync   <= '0;
      sc_sync   <= '0;
      fin_sync  <= '0;
      dead_sync <= '0;
      vs_d      <= 1'b0;
      sc_d      <= 1'b0;
    end else begin
      vs_sync   <= {vs_sync[SYNC_STAGES-2:0],   bus.i_v_sync};
      sc_sync   <= {sc_sync[SYNC_STAGES-2:0],   bus.i_scored};
      fin_sync  <= {fin_sync[SYNC_STAGES-2:0],  bus.i_is_finished};
      dead_sync <= {dead_sync[SYNC_STAGES-2:0], bus.i_is_dead};
      vs_d      <= vs_sync[SYNC_STAGES-1];
      sc_d      <= sc_sync[SYNC_STAGES-1];
    end
  end

  logic frame_start, coin_edge, game_end;
  assign frame_start = vs_sync[SYNC_STAGES-1] & ~vs_d;
  assign coin_edge   = sc_sync[SYNC_STAGES-1] & ~sc_d;
  assign game_end    = fin_sync[SYNC_STAGES-1] | dead_sync[SYNC_STAGES-1];

  // Ripple BCD adder; carry out of the MSD means the sum passed 9999
  state_t     state_q, state_d;
  bcd_score_t score_q, score_d, sum_bcd, addend, credited;
  logic [4:0] carry;
  logic       event_q, credit;

  assign addend   = {12'h000, ADDEND0};
  assign carry[0] = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_dig
    bcd_digit_add u_dig (
      .a   (score_q[g]),
      .b   (addend[g]),
      .cin (carry[g]),
      .sum (sum_bcd[g]),
      .cout(carry[g+1])
    );
  end

  assign credited = carry[4] ? SCORE_MAX : sum_bcd;

  // Restart beats game end and coin; game end beats coin.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    credit  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.i_restart) begin
          score_d = '0;
          state_d = ST_RUN;
        end else if (game_end) begin
          state_d = ST_OVER;
        end else if (coin_edge) begin
          score_d = credited;
          credit  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.i_restart) begin
          score_d = '0;
          state_d = ST_RUN;
        end else if (game_end) begin
          state_d = ST_OVER;
        end else if (frame_start) begin
          state_d = ST_RUN;
        end
      end
      ST_OVER: begin
        if (bus.i_restart) begin
          score_d = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_RUN;
      score_q <= '0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      event_q <= credit;
    end
  end

`ifdef SCORE_TRACKER_BEST_EN
  bcd_score_t best_q;
  always_ff @(posedge i_clk) begin
    if (i_rst)
      best_q <= '0;
    else if (state_q != ST_OVER && state_d == ST_OVER && bcd_gt(score_q, best_q))
      best_q <= score_q;
  end
  assign bus.o_best_bcd = best_q;
`else
  assign bus.o_best_bcd = '0;
`endif

  assign bus.o_score_bcd   = score_q;
  assign bus.o_score_event = event_q;
  assign bus.o_state       = state_q;
endmodule
